// File: rtl/main_seq_arbiter_if.sv
// rtl/main_seq_arbiter_if.sv - requester and datapath signal bundle for main_seq_arbiter
// Purpose: groups the two requester channels and the main datapath handshake.
// Ports (slave = arbiter view):
//   in : req[1:0], x0/x1[7:0], on0/on1[1:0], dp_y[7:0], dp_active
//   out: gnt[1:0], done[1:0], result[7:0], timeout, dp_x[7:0], dp_on[1:0], dp_start, busy
interface main_seq_arbiter_if;
  logic [1:0] req;
  logic [7:0] x0;
  logic [1:0] on0;
  logic [7:0] x1;
  logic [1:0] on1;
  logic [1:0] gnt;
  logic [1:0] done;
  logic [7:0] result;
  logic       timeout;
  logic [7:0] dp_x;
  logic [1:0] dp_on;
  logic       dp_start;
  logic [7:0] dp_y;
  logic       dp_active;
  logic       busy;

  modport slave (
    input  req, x0, on0, x1, on1, dp_y, dp_active,
    output gnt, done, result, timeout, dp_x, dp_on, dp_start, busy
  );

  modport master (
    output req, x0, on0, x1, on1, dp_y, dp_active,
    input  gnt, done, result, timeout, dp_x, dp_on, dp_start, busy
  );
endinterface

// File: rtl/main_seq_arbiter.sv
// rtl/main_seq_arbiter.sv - round-robin two-way arbiter and sequencer for the main datapath
// Purpose: grants the datapath to one of two requesters, holds x/on stable for a setup
// cycle, pulses dp_start for START_LEN cycles, waits for dp_active to drop (bounded by
// TIMEOUT cycles) and returns the captured dp_y with a one-cycle done pulse.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : main_seq_arbiter_if.slave (requesters + datapath), all outputs registered
module main_seq_arbiter #(
  parameter int START_LEN = 13,
  parameter int TIMEOUT   = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  main_seq_arbiter_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, SETUP, RUN, DRAIN, DONE} state_e;

  localparam logic [7:0] START_LAST = 8'(START_LEN - 1);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       last_q, last_d;
  logic       win_q, win_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] done_q, done_d;
  logic [7:0] result_q, result_d;
  logic       timeout_q, timeout_d;
  logic [7:0] dp_x_q, dp_x_d;
  logic [1:0] dp_on_q, dp_on_d;
  logic       dp_start_q, dp_start_d;
  logic       busy_q, busy_d;
  logic       w_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      last_q     <= 1'b1;  // requester 0 wins the first contended grant
      win_q      <= 1'b0;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      result_q   <= 8'h00;
      timeout_q  <= 1'b0;
      dp_x_q     <= 8'h00;
      dp_on_q    <= 2'b00;
      dp_start_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_q     <= last_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      result_q   <= result_d;
      timeout_q  <= timeout_d;
      dp_x_q     <= dp_x_d;
      dp_on_q    <= dp_on_d;
      dp_start_q <= dp_start_d;
      busy_q     <= busy_d;
    end
  end

  // With both requesting, the one that did not win last time goes; otherwise the lone requester.
  assign w_sel = (bus.req == 2'b11) ? ~last_q : bus.req[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    win_d      = win_q;
    gnt_d      = gnt_q;
    done_d     = done_q;
    result_d   = result_q;
    timeout_d  = timeout_q;
    dp_x_d     = dp_x_q;
    dp_on_d    = dp_on_q;
    dp_start_d = dp_start_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (bus.req != 2'b00) begin
          win_d   = w_sel;
          gnt_d   = w_sel ? 2'b10 : 2'b01;
          dp_x_d  = w_sel ? bus.x1 : bus.x0;
          dp_on_d = w_sel ? bus.on1 : bus.on0;
          busy_d  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        // operands have been stable for a full cycle before start rises
        dp_start_d = 1'b1;
        cnt_d      = 8'd0;
        state_d    = RUN;
      end
      RUN: begin
        if (cnt_q == START_LAST) begin
          dp_start_d = 1'b0;
          cnt_d      = 8'd0;
          state_d    = DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        if (!bus.dp_active) begin
          result_d  = bus.dp_y;
          done_d    = gnt_q;
          timeout_d = 1'b0;
          state_d   = DONE;
        end else if (cnt_q == TO_LAST) begin
          result_d  = 8'h00;
          done_d    = gnt_q;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        // one cycle here gives a registered requester time to drop req before IDLE samples it
        done_d    = 2'b00;
        timeout_d = 1'b0;
        gnt_d     = 2'b00;
        busy_d    = 1'b0;
        last_d    = win_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.timeout  = timeout_q;
  assign bus.dp_x     = dp_x_q;
  assign bus.dp_on    = dp_on_q;
  assign bus.dp_start = dp_start_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_main_seq_arbiter.sv
// tb/tb_main_seq_arbiter.sv - scoreboard testbench for main_seq_arbiter
module tb_main_seq_arbiter;

  typedef struct {
    logic [1:0] done;
    logic [7:0] result;
    logic       timeout;
    logic [7:0] dp_x;
    logic [1:0] dp_on;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  main_seq_arbiter_if ifa ();
  main_seq_arbiter_if ifb ();

  main_seq_arbiter dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
  main_seq_arbiter #(.START_LEN(1), .TIMEOUT(1)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 'h%0h expected 'h%0h", name, act, exp);
  endtask

  // datapath models: busy while start is high, idle ma_delay cycles after it falls
  int         ma_delay = 0;
  bit         ma_stuck = 0;
  logic [7:0] ma_key = 8'h00;
  int         ma_cnt = 0;
  bit         mb_stuck = 0;
  logic [7:0] mb_key = 8'h55;

  always @(negedge clk) begin
    if (ifa.dp_start) begin
      ifa.dp_active = 1'b1;
      ifa.dp_y      = ifa.dp_x ^ ma_key;
      ma_cnt        = 0;
    end else if (ifa.dp_active && !ma_stuck) begin
      if (ma_cnt >= ma_delay) ifa.dp_active = 1'b0;
      else ma_cnt++;
    end
    if (ifb.dp_start) begin
      ifb.dp_active = 1'b1;
      ifb.dp_y      = ifb.dp_x ^ mb_key;
    end else if (ifb.dp_active && !mb_stuck) begin
      ifb.dp_active = 1'b0;
    end
  end

  // monitor for DUT A: pops an expectation on every done pulse
  int         cyc = 0;
  int         gnt_cyc = 0;
  int         slen = 0;
  logic [1:0] prev_gnt = 2'b00;

  always @(negedge clk) begin
    cyc++;
    if (ifa.gnt != 2'b00 && prev_gnt == 2'b00) begin
      gnt_cyc = cyc;
      slen    = 0;
    end
    prev_gnt = ifa.gnt;
    if (ifa.dp_start) slen++;
    if (ifa.done != 2'b00) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(ifa.done), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("done", 32'(ifa.done), 32'(mon_e.done));
        chk("gnt_at_done", 32'(ifa.gnt), 32'(mon_e.done));
        chk("result", 32'(ifa.result), 32'(mon_e.result));
        chk("timeout", 32'(ifa.timeout), 32'(mon_e.timeout));
        chk("dp_x", 32'(ifa.dp_x), 32'(mon_e.dp_x));
        chk("dp_on", 32'(ifa.dp_on), 32'(mon_e.dp_on));
        chk("latency", 32'(cyc - gnt_cyc), 32'(mon_e.lat));
        chk("start_len", 32'(slen), 32'd13);
      end
    end
  end

  task automatic push(input logic [1:0] d, input logic [7:0] r, input logic t,
                      input logic [7:0] x, input logic [1:0] o, input int lat);
    exp_t e;
    e.done = d; e.result = r; e.timeout = t; e.dp_x = x; e.dp_on = o; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic wait_gnt_a(input string name);
    int n = 0;
    while (ifa.gnt == 2'b00 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (ifa.gnt == 2'b00) chk(name, 32'd0, 32'd1);
  endtask

  // returns in the DONE cycle of the last expected operation, so req can drop in time
  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk); #1; n++;
    end
    if (sb.size() != 0) begin
      chk("drain_wait", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  task automatic wait_idle_a();
    int n = 0;
    while (ifa.busy && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("idle_wait", 32'(ifa.busy), 32'd0);
  endtask

  task automatic run_b(input bit stuck, input logic [7:0] exp_res, input logic exp_to);
    int n = 0;
    int k = 0;
    int starts = 0;
    bit seen = 0;
    mb_stuck = stuck;
    ifb.req = 2'b01;
    while (ifb.gnt == 2'b00 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    chk("b_gnt", 32'(ifb.gnt), 32'h1);
    while (!seen && k < 20) begin
      @(negedge clk); #1; k++;
      if (ifb.dp_start) starts++;
      if (ifb.done != 2'b00) begin
        seen = 1;
        ifb.req = 2'b00;
        chk("b_done", 32'(ifb.done), 32'h1);
        chk("b_latency", 32'(k), 32'd3);
        chk("b_start_len", 32'(starts), 32'd1);
        chk("b_timeout", 32'(ifb.timeout), 32'(exp_to));
        chk("b_result", 32'(ifb.result), 32'(exp_res));
      end
    end
    if (!seen) begin
      chk("b_done_wait", 32'd0, 32'd1);
      ifb.req = 2'b00;
    end
    @(negedge clk); #1;
    mb_stuck = 0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("b_idle", 32'(ifb.busy), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_time_limit: got 1 expected 0");
    $fatal(1);
  end

  initial begin
    ifa.req = 2'b00; ifa.x0 = 8'h00; ifa.on0 = 2'b00; ifa.x1 = 8'h00; ifa.on1 = 2'b00;
    ifa.dp_y = 8'h00; ifa.dp_active = 1'b0;
    ifb.req = 2'b00; ifb.x0 = 8'h3C; ifb.on0 = 2'b10; ifb.x1 = 8'h00; ifb.on1 = 2'b00;
    ifb.dp_y = 8'h00; ifb.dp_active = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_gnt", 32'(ifa.gnt), 32'd0);
    chk("rst_done", 32'(ifa.done), 32'd0);
    chk("rst_result", 32'(ifa.result), 32'd0);
    chk("rst_timeout", 32'(ifa.timeout), 32'd0);
    chk("rst_dp_x", 32'(ifa.dp_x), 32'd0);
    chk("rst_dp_on", 32'(ifa.dp_on), 32'd0);
    chk("rst_dp_start", 32'(ifa.dp_start), 32'd0);
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    rst_n = 1'b1;

    // single request, datapath idles 3 cycles after start falls: 05^A6 = A3
    @(negedge clk); #1;
    ma_delay = 3; ma_key = 8'hA6;
    ifa.x0 = 8'h05; ifa.on0 = 2'b01;
    push(2'b01, 8'hA3, 1'b0, 8'h05, 2'b01, 18);
    ifa.req = 2'b01;
    wait_gnt_a("t1_gnt_wait");
    chk("t1_gnt", 32'(ifa.gnt), 32'h1);
    chk("t1_dp_x", 32'(ifa.dp_x), 32'h05);
    chk("t1_dp_on", 32'(ifa.dp_on), 32'h1);
    chk("t1_busy", 32'(ifa.busy), 32'd1);
    wait_drain(100);
    ifa.req = 2'b00;
    @(negedge clk); #1;
    chk("t1_gnt_clear", 32'(ifa.gnt), 32'd0);
    chk("t1_busy_clear", 32'(ifa.busy), 32'd0);
    chk("t1_done_clear", 32'(ifa.done), 32'd0);
    chk("t1_result_hold", 32'(ifa.result), 32'hA3);

    // both held: strict alternation starting with requester 0
    pulse_reset();
    ma_delay = 0; ma_key = 8'h30;
    ifa.x0 = 8'h01; ifa.on0 = 2'b01; ifa.x1 = 8'h09; ifa.on1 = 2'b11;
    push(2'b01, 8'h31, 1'b0, 8'h01, 2'b01, 15);
    push(2'b10, 8'h39, 1'b0, 8'h09, 2'b11, 15);
    push(2'b01, 8'h31, 1'b0, 8'h01, 2'b01, 15);
    push(2'b10, 8'h39, 1'b0, 8'h09, 2'b11, 15);
    ifa.req = 2'b11;
    wait_drain(200);
    ifa.req = 2'b00;
    wait_idle_a();

    // watchdog: stuck datapath, then a normal operation
    ma_stuck = 1; ifa.x0 = 8'h05; ifa.on0 = 2'b01;
    push(2'b01, 8'h00, 1'b1, 8'h05, 2'b01, 46);
    ifa.req = 2'b01;
    wait_drain(100);
    ifa.req = 2'b00;
    ma_stuck = 0;
    wait_idle_a();
    ifa.x0 = 8'h07;
    push(2'b01, 8'h37, 1'b0, 8'h07, 2'b01, 15);
    ifa.req = 2'b01;
    wait_drain(100);
    ifa.req = 2'b00;
    wait_idle_a();

    // asynchronous reset in the 5th RUN cycle
    ifa.x0 = 8'h05; ifa.req = 2'b01;
    wait_gnt_a("t4_gnt_wait");
    repeat (5) @(negedge clk);
    #1;
    chk("t4_start_before", 32'(ifa.dp_start), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_start_async", 32'(ifa.dp_start), 32'd0);
    chk("t4_gnt_async", 32'(ifa.gnt), 32'd0);
    chk("t4_busy_async", 32'(ifa.busy), 32'd0);
    @(negedge clk); #1;
    ifa.x0 = 8'h03; ifa.on0 = 2'b01; ifa.x1 = 8'h0A; ifa.on1 = 2'b10;
    push(2'b01, 8'h33, 1'b0, 8'h03, 2'b01, 15);
    push(2'b10, 8'h3A, 1'b0, 8'h0A, 2'b10, 15);
    ifa.req = 2'b11;
    rst_n = 1'b1;
    wait_drain(200);
    ifa.req = 2'b00;
    wait_idle_a();

    // requester 0 drops req and changes x0 mid-RUN; mode 00 passes through
    pulse_reset();
    ifa.x0 = 8'h11; ifa.on0 = 2'b00; ifa.x1 = 8'h22; ifa.on1 = 2'b10;
    push(2'b01, 8'h21, 1'b0, 8'h11, 2'b00, 15);
    push(2'b10, 8'h12, 1'b0, 8'h22, 2'b10, 15);
    ifa.req = 2'b11;
    wait_gnt_a("t5_gnt_wait");
    repeat (5) @(negedge clk);
    #1;
    ifa.req = 2'b10; ifa.x0 = 8'hFF;
    @(negedge clk); #1;
    chk("t5_dp_x_mid", 32'(ifa.dp_x), 32'h11);
    wait_drain(200);
    ifa.req = 2'b00;
    wait_idle_a();

    // START_LEN=1, TIMEOUT=1 instance: 3C^55 = 69
    run_b(1'b0, 8'h69, 1'b0);
    run_b(1'b1, 8'h00, 1'b1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/main_seq_arbiter.md
Name: main_seq_arbiter

Overview:
- Controller and two-way arbiter in front of the `main` datapath (x/on/start in; y/active/regime out).
- Two requesters each submit an operand and a mode.
- The block grants the datapath round-robin, drives x/on/start with the required setup and start-hold timing, and waits for `active` to drop.
- It then returns `y` to the winner with a one-cycle done pulse; a watchdog covers a datapath that never goes idle.

Parameters:
START_LEN, 13, number of cycles dp_start is held high per operation (1..255)
TIMEOUT, 32, max DRAIN cycles waiting for dp_active low before abort (1..255)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
req  input  2  request per requester; held high until its done pulse
x0  input  8  operand, requester 0
on0  input  2  mode, requester 0
x1  input  8  operand, requester 1
on1  input  2  mode, requester 1
gnt  output  2  one-hot grant; high from GRANT through DONE
done  output  2  one-cycle completion pulse to granted requester
result  output  8  captured dp_y; valid during done, held until next capture
timeout  output  1  high with done when the watchdog fired
dp_x  output  8  operand to datapath
dp_on  output  2  mode to datapath
dp_start  output  1  start to datapath
dp_y  input  8  datapath result
dp_active  input  1  datapath busy
busy  output  1  high in any state except IDLE

Behaviour:
- All outputs registered.
- Reset (rst=0, async) forces:
  - state=IDLE, gnt=0, done=0, result=0, timeout=0.
  - dp_x=0, dp_on=0, dp_start=0, busy=0.
  - Round-robin pointer last=1, so requester 0 wins first.
- Reset mid-operation drops dp_start immediately (async). The operation is lost; requesters must re-request.
- States: IDLE, SETUP, RUN, DRAIN, DONE.
- IDLE → SETUP when req != 0:
  - Winner: the only requester if one is asserted; if both, the requester != last.
  - On that edge: gnt=onehot(w), dp_x=x_w, dp_on=on_w, busy=1.
  - x_w/on_w are sampled once; later changes are ignored.
- SETUP lasts exactly 1 cycle, so dp_x/dp_on are stable before start → RUN, dp_start=1, counter=0.
- RUN:
  - dp_start=1 for exactly START_LEN cycles; counter increments each cycle.
  - On the edge where counter==START_LEN-1: dp_start=0, counter=0, → DRAIN.
- DRAIN, sampling dp_active each edge:
  - dp_active==0: result=dp_y, done=onehot(w), timeout=0, → DONE.
  - Else if counter==TIMEOUT-1: result=8'h00, done=onehot(w), timeout=1, → DONE.
  - Else counter++.
- DONE lasts 1 cycle, then → IDLE:
  - On that edge: done=0, timeout=0, gnt=0, busy=0, last=w.
  - result holds its value.
- The one-cycle DONE lets a registered requester drop req before IDLE samples it.
- No back-to-back reuse: minimum IDLE occupancy is 1 cycle between operations.
- Latency, with the grant edge = edge 0:
  - dp_start high after edges 1..START_LEN.
  - Earliest done is after edge START_LEN+2 (dp_active already low on the first DRAIN sample).
- req deasserted mid-operation: ignored; the operation completes and done still pulses.
- req of the non-granted requester is ignored until IDLE.
- Both requesters held continuously: grants strictly alternate 0,1,0,1…
- on=2'b00 is passed through unchanged; no mode checking.
- dp_x/dp_on hold their last values after completion (not cleared).

Test Plan:
1. Reset, release rst; req=01, x0=8'h05, on0=2'b01; model drops dp_active 3 cycles after dp_start falls, dp_y=8'hA3.
   → gnt=01, dp_x=05, dp_on=01 after edge 0; dp_start high exactly 13 cycles; done=01 with result=A3, timeout=0; gnt=0 one cycle later.
2. req=11 held continuously, x0=8'h01/on0=01, x1=8'h09/on1=11, fast datapath.
   → grants 0,1,0,1; dp_x alternates 01/09, dp_on alternates 01/11; result tracks each dp_y.
3. dp_active stuck at 1 after start.
   → done pulses exactly 32 cycles into DRAIN with timeout=1, result=00; next request proceeds normally.
4. Assert rst=0 asynchronously at the 5th RUN cycle.
   → dp_start, gnt, busy low immediately (before the next edge); after release, req=10 is granted to requester 1 only if req=01 is absent (last=1 → requester 0 preferred).
5. Requester 0 drops req and changes x0 to 8'hFF mid-RUN.
   → dp_x stays at the originally sampled value; done=01 still pulses; requester 1's pending req is granted in the following GRANT.
6. START_LEN=1, TIMEOUT=1.
   → dp_start is a single-cycle pulse; done occurs on the first DRAIN edge, with timeout=1 if dp_active=1 at that edge.
